// File: rtl/dvs_ravens_pkg.sv
// -----------------------------------------------------------------------------
// dvs_ravens_pkg
// Shared types and constants for the DVS event path and the RAVENS packet
// link: event word layout, packet tags, scheduler FSM states, and a helper
// that decides whether a timestamp delta fits the short packet form.
// -----------------------------------------------------------------------------
package dvs_ravens_pkg;

    localparam int X_BITS          = 9;
    localparam int Y_BITS          = 9;
    localparam int TS_BITS         = 47;
    localparam int EVENT_BITS      = X_BITS + Y_BITS + 1 + TS_BITS;  // 66
    localparam int RAVENS_PKT_BITS = 32;
    localparam int DELTA_BITS      = 11;

    // Split point of the timestamp between the TSH and TSL packets.
    localparam int TS_LO_BITS      = 17;

    localparam logic [1:0] PKT_TAG_SHORT = 2'b00;
    localparam logic [1:0] PKT_TAG_HDR   = 2'b01;
    localparam logic [1:0] PKT_TAG_TSH   = 2'b10;
    localparam logic [1:0] PKT_TAG_TSL   = 2'b11;

    typedef enum logic [2:0] {
        SCH_IDLE,
        SCH_P0,
        SCH_P1,
        SCH_P2
    } sched_state_t;

    // Event word as it leaves the queue: {x, y, pol, ts}, x in the MSBs.
    typedef struct packed {
        logic [X_BITS-1:0]  x;
        logic [Y_BITS-1:0]  y;
        logic               pol;
        logic [TS_BITS-1:0] ts;
    } dvs_event_t;

    // True when the delta is representable in the short-form payload.
    function automatic logic delta_fits(input logic [TS_BITS-1:0] delta);
        return (delta[TS_BITS-1:DELTA_BITS] == '0);
    endfunction

endpackage

// File: rtl/ravens_pkt_fmt.sv
// -----------------------------------------------------------------------------
// ravens_pkt_fmt
// Purely combinational packet formatter. Maps the captured event, the current
// scheduler state and the short-form flag/delta to the 32-bit packet payload.
// Outside P0..P2 the payload is all zeros.
//
// Ports:
//   evt_i       in   EVENT_W     captured event word
//   state_i     in   3           scheduler state (sched_state_t encoding)
//   short_i     in   1           current event uses the single-packet form
//   delta_i     in   DELTA_BITS  timestamp delta for the short form
//   pkt_data_o  out  PKT_W       packet payload
// -----------------------------------------------------------------------------
module ravens_pkt_fmt
    import dvs_ravens_pkg::*;
#(
    parameter int EVENT_W = EVENT_BITS,
    parameter int PKT_W   = RAVENS_PKT_BITS
) (
    input  logic [EVENT_W-1:0]    evt_i,
    input  logic [2:0]            state_i,
    input  logic                  short_i,
    input  logic [DELTA_BITS-1:0] delta_i,
    output logic [PKT_W-1:0]      pkt_data_o
);

    dvs_event_t evt;
    assign evt = evt_i;

    // NOTE: every signal written in an always_comb gets a default on its
    // first line, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        pkt_data_o = '0;
        case (state_i)
            SCH_P0: begin
                if (short_i) begin
                    pkt_data_o = {PKT_TAG_SHORT, evt.x, evt.y, evt.pol, delta_i};
                end else begin
                    pkt_data_o = {PKT_TAG_HDR, evt.x, evt.y, evt.pol,
                                  {DELTA_BITS{1'b0}}};
                end
            end
            SCH_P1:  pkt_data_o = {PKT_TAG_TSH, evt.ts[TS_BITS-1:TS_LO_BITS]};
            SCH_P2:  pkt_data_o = {PKT_TAG_TSL, 13'b0, evt.ts[TS_LO_BITS-1:0]};
            default: pkt_data_o = '0;
        endcase
    end

endmodule

// File: rtl/ravens_pkt_sched.sv
// -----------------------------------------------------------------------------
// ravens_pkt_sched
// Drains the DVS event queue (first-word-fall-through FIFO) and serializes
// each event into RAVENS packets over a valid/ready link. Long form is three
// packets (HDR, TSH, TSL); back-to-back events follow with no bubble.
//
// Build option: define RAVENS_TS_DELTA_EN to enable timestamp-delta
// compression. An event whose timestamp is within 2^11 of the previously
// captured one is then sent as a single short packet.
//
// Ports:
//   clk        in   1        clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   en         in   1        permit popping new events
//   evt_empty  in   1        queue empty
//   evt_data   in   EVENT_W  head-of-queue event
//   evt_rd_en  out  1        pop strobe, one cycle per event
//   pkt_data   out  PKT_W    packet payload
//   pkt_valid  out  1        packet valid
//   pkt_ready  in   1        downstream accepts
//   busy       out  1        an event is being serialized
//   evt_sent   out  CNT_W    count of fully transferred events (wraps)
// -----------------------------------------------------------------------------
module ravens_pkt_sched
    import dvs_ravens_pkg::*;
#(
    parameter int EVENT_W = EVENT_BITS,
    parameter int PKT_W   = RAVENS_PKT_BITS,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               evt_empty,
    input  logic [EVENT_W-1:0] evt_data,
    output logic               evt_rd_en,
    output logic [PKT_W-1:0]   pkt_data,
    output logic               pkt_valid,
    input  logic               pkt_ready,
    output logic               busy,
    output logic [CNT_W-1:0]   evt_sent
);

    sched_state_t          state_q, state_d;
    logic [EVENT_W-1:0]    evt_q, evt_d;
    logic [CNT_W-1:0]      sent_q, sent_d;
    logic                  short_q;
    logic [DELTA_BITS-1:0] delta_q;

    logic xfer;
    logic last_pkt;
    logic capture;

    assign pkt_valid = (state_q != SCH_IDLE);
    assign busy      = pkt_valid;
    assign xfer      = pkt_valid && pkt_ready;
    assign evt_sent  = sent_q;

    // The packet now on the link is the event's last one.
    assign last_pkt = (state_q == SCH_P2) || ((state_q == SCH_P0) && short_q);

    // Pop from IDLE, or chain the next event onto the final transfer.
    assign capture = en && !evt_empty &&
                     ((state_q == SCH_IDLE) || (xfer && last_pkt));

    // While reset is held the FSM sits in IDLE, which would otherwise let
    // capture pop (and lose) an event; the strobe is masked by reset.
    assign evt_rd_en = capture && rst_n;

`ifdef RAVENS_TS_DELTA_EN
    logic [TS_BITS-1:0]    prev_ts_q, prev_ts_d;
    logic                  have_prev_q, have_prev_d;
    logic                  short_d;
    logic [DELTA_BITS-1:0] delta_d;
    logic [TS_BITS-1:0]    delta_full;
    dvs_event_t            head;

    assign head = evt_data;

    // Modular subtraction: a wrapped timestamp still yields a small delta.
    assign delta_full = head.ts - prev_ts_q;

    always_comb begin
        prev_ts_d   = prev_ts_q;
        have_prev_d = have_prev_q;
        short_d     = short_q;
        delta_d     = delta_q;
        // evt_data is only consumed on capture, which implies a non-empty queue.
        if (capture) begin
            prev_ts_d   = head.ts;
            have_prev_d = 1'b1;
            short_d     = have_prev_q && delta_fits(delta_full);
            delta_d     = delta_full[DELTA_BITS-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_ts_q   <= '0;
            have_prev_q <= 1'b0;
            short_q     <= 1'b0;
            delta_q     <= '0;
        end else begin
            prev_ts_q   <= prev_ts_d;
            have_prev_q <= have_prev_d;
            short_q     <= short_d;
            delta_q     <= delta_d;
        end
    end
`else
    assign short_q = 1'b0;
    assign delta_q = '0;
`endif

    always_comb begin
        state_d = state_q;
        evt_d   = evt_q;
        sent_d  = sent_q;

        if (capture) begin
            evt_d = evt_data;
        end

        if (xfer && last_pkt) begin
            sent_d = sent_q + CNT_W'(1);
        end

        case (state_q)
            SCH_IDLE: begin
                if (capture) state_d = SCH_P0;
            end
            SCH_P0: begin
                if (xfer) begin
                    if (short_q) state_d = capture ? SCH_P0 : SCH_IDLE;
                    else         state_d = SCH_P1;
                end
            end
            SCH_P1: begin
                if (xfer) state_d = SCH_P2;
            end
            SCH_P2: begin
                if (xfer) state_d = capture ? SCH_P0 : SCH_IDLE;
            end
            default: state_d = SCH_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCH_IDLE;
            evt_q   <= '0;
            sent_q  <= '0;
        end else begin
            state_q <= state_d;
            evt_q   <= evt_d;
            sent_q  <= sent_d;
        end
    end

    ravens_pkt_fmt #(
        .EVENT_W (EVENT_W),
        .PKT_W   (PKT_W)
    ) u_fmt (
        .evt_i      (evt_q),
        .state_i    (state_q),
        .short_i    (short_q),
        .delta_i    (delta_q),
        .pkt_data_o (pkt_data)
    );

endmodule
